// File: rtl/oric_sdram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | oric_sdram_arbiter: shares the toggle-handshake SDRAM port between the   |
// | Oric CPU bus and the buffered loader/FDC write stream.  Rev 1.0          |
// +--------------------------------------------------------------------------+
module oric_sdram_arbiter #(
  parameter int             SD_AW    = 24,
  parameter int             FIFO_DEP = 4,
  parameter logic [SD_AW:0] CPU_BASE = '0
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             cpu_cs,
  input  logic             cpu_oe,
  input  logic             cpu_we,
  input  logic [15:0]      cpu_a,
  input  logic [7:0]       cpu_d,
  output logic [7:0]       cpu_q,
  input  logic             ldr_wr,
  input  logic [SD_AW:0]   ldr_a,
  input  logic [7:0]       ldr_d,
  output logic             ldr_full,
  output logic             ldr_ovf,
  output logic             sd_req,
  input  logic             sd_ack,
  output logic [SD_AW-1:0] sd_a,
  output logic [1:0]       sd_ds,
  output logic             sd_we,
  output logic [15:0]      sd_d,
  input  logic [15:0]      sd_q
);

  localparam int           PW    = $clog2(FIFO_DEP);
  localparam logic [PW:0]  DEP_C = (PW+1)'(FIFO_DEP);

  typedef enum logic [1:0] {SYNC, IDLE, CPU_WAIT, LDR_WAIT} state_t;

  logic           rd_lvl, wr_lvl, event_cpu;
  logic           rd_prev_q, wr_prev_q;
  logic [15:0]    a_prev_q;
  logic [SD_AW:0] cpu_byte_a;

  logic [SD_AW:0] fifo_a_mem [FIFO_DEP];
  logic [7:0]     fifo_d_mem [FIFO_DEP];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PW:0]    cnt_q, cnt_d;
  logic           push, pop, fifo_ne, ack_match, ovf_q;

  state_t         state_q;
  logic           pend_q, last_cpu_q, lat_we_q, rd_a0_q;
  logic [SD_AW:0] lat_a_q;
  logic [7:0]     lat_d_q;
  logic           sd_req_q, sd_we_q;
  logic [SD_AW-1:0] sd_a_q;
  logic [1:0]     sd_ds_q;
  logic [15:0]    sd_d_q;
  logic [7:0]     cpu_q_q;

  assign rd_lvl     = cpu_cs & cpu_oe;
  assign wr_lvl     = cpu_cs & cpu_we;
  // A read held across an address change is a new access (the CPU keeps oe asserted).
  assign event_cpu  = (rd_lvl & ~rd_prev_q) | (wr_lvl & ~wr_prev_q) |
                      (rd_lvl & (cpu_a != a_prev_q));
  assign cpu_byte_a = {{(SD_AW-15){1'b0}}, cpu_a} + CPU_BASE;

  assign ack_match = (sd_ack == sd_req_q);
  assign pop       = (state_q == LDR_WAIT) & ack_match;
  assign push      = ldr_wr & ~ldr_full;
  assign fifo_ne   = (cnt_q != '0);
  assign ldr_full  = (cnt_q == DEP_C);
  assign ldr_ovf   = ovf_q;

  assign cpu_q  = cpu_q_q;
  assign sd_req = sd_req_q;
  assign sd_a   = sd_a_q;
  assign sd_ds  = sd_ds_q;
  assign sd_we  = sd_we_q;
  assign sd_d   = sd_d_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
      a_prev_q  <= '0;
    end else begin
      rd_prev_q <= rd_lvl;
      wr_prev_q <= wr_lvl;
      a_prev_q  <= cpu_a;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_a_mem[wr_ptr_q] <= ldr_a;
      fifo_d_mem[wr_ptr_q] <= ldr_d;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push)             wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)              rd_ptr_q <= rd_ptr_q + 1'b1;
      if (ldr_wr && ldr_full) ovf_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SYNC;
      pend_q     <= 1'b0;
      last_cpu_q <= 1'b0;
      lat_a_q    <= '0;
      lat_d_q    <= '0;
      lat_we_q   <= 1'b0;
      rd_a0_q    <= 1'b0;
      sd_req_q   <= 1'b0;
      sd_a_q     <= '0;
      sd_ds_q    <= '0;
      sd_we_q    <= 1'b0;
      sd_d_q     <= '0;
      cpu_q_q    <= '0;
    end else begin
      case (state_q)
        SYNC: begin
          sd_req_q <= sd_ack;
          state_q  <= IDLE;
        end
        IDLE: begin
          if (pend_q && !(last_cpu_q && fifo_ne)) begin
            sd_a_q     <= lat_a_q[SD_AW:1];
            sd_ds_q    <= lat_we_q ? (lat_a_q[0] ? 2'b10 : 2'b01) : 2'b11;
            sd_we_q    <= lat_we_q;
            sd_d_q     <= {lat_d_q, lat_d_q};
            rd_a0_q    <= lat_a_q[0];
            sd_req_q   <= ~sd_req_q;
            pend_q     <= 1'b0;
            last_cpu_q <= 1'b1;
            state_q    <= CPU_WAIT;
          end else if (fifo_ne) begin
            sd_a_q     <= fifo_a_mem[rd_ptr_q][SD_AW:1];
            sd_ds_q    <= fifo_a_mem[rd_ptr_q][0] ? 2'b10 : 2'b01;
            sd_we_q    <= 1'b1;
            sd_d_q     <= {fifo_d_mem[rd_ptr_q], fifo_d_mem[rd_ptr_q]};
            sd_req_q   <= ~sd_req_q;
            last_cpu_q <= 1'b0;
            state_q    <= LDR_WAIT;
          end
        end
        CPU_WAIT: begin
          if (ack_match) begin
            if (!sd_we_q) cpu_q_q <= rd_a0_q ? sd_q[15:8] : sd_q[7:0];
            state_q <= IDLE;
          end
        end
        LDR_WAIT: begin
          if (ack_match) state_q <= IDLE;
        end
        default: state_q <= SYNC;
      endcase
      // Placed after the issue logic so a same-cycle event keeps the request pending.
      if (event_cpu) begin
        pend_q   <= 1'b1;
        lat_a_q  <= cpu_byte_a;
        lat_d_q  <= cpu_d;
        lat_we_q <= cpu_we;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oric_sdram_arbiter.sv
`default_nettype none
// Directed bench for oric_sdram_arbiter: CPU vector table plus hand sequences for
// sync, single-toggle writes, FIFO overflow, CPU/loader alternation and mid-transfer reset.
module tb_oric_sdram_arbiter;

  logic        clk_sys = 1'b0, reset_n = 1'b0;
  logic        cpu_cs = 1'b0, cpu_oe = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_a = '0;
  logic [7:0]  cpu_d = '0;
  logic [7:0]  cpu_q;
  logic        ldr_wr = 1'b0;
  logic [24:0] ldr_a = '0;
  logic [7:0]  ldr_d = '0;
  logic        ldr_full, ldr_ovf, sd_req, sd_we;
  logic        sd_ack = 1'b0;
  logic [23:0] sd_a;
  logic [1:0]  sd_ds;
  logic [15:0] sd_d;
  logic [15:0] sd_q = '0;

  int n_tot = 0, n_pass = 0;

  oric_sdram_arbiter #(.SD_AW(24), .FIFO_DEP(4), .CPU_BASE(25'h0)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .cpu_cs(cpu_cs), .cpu_oe(cpu_oe), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
    .cpu_q(cpu_q),
    .ldr_wr(ldr_wr), .ldr_a(ldr_a), .ldr_d(ldr_d), .ldr_full(ldr_full), .ldr_ovf(ldr_ovf),
    .sd_req(sd_req), .sd_ack(sd_ack), .sd_a(sd_a), .sd_ds(sd_ds), .sd_we(sd_we),
    .sd_d(sd_d), .sd_q(sd_q)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        we;
    logic [15:0] a;
    logic [7:0]  d;
    logic [15:0] q;
    logic [23:0] e_sa;
    logic [1:0]  e_ds;
    logic [15:0] e_sd;
    logic [7:0]  e_cq;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wait_issue(input string nm, output int n);
    n = 0;
    while (sd_req == sd_ack && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    chk(nm, 32'(sd_req != sd_ack), 32'd1);
  endtask

  task automatic do_ack(input logic [15:0] q);
    sd_q   = q;
    sd_ack = sd_req;
    @(negedge clk_sys);
  endtask

  task automatic push(input logic [24:0] a, input logic [7:0] d);
    ldr_wr = 1'b1;
    ldr_a  = a;
    ldr_d  = d;
    @(negedge clk_sys);
    ldr_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    vt[0] = '{we:1'b0, a:16'h1235, d:8'h00, q:16'hBEEF, e_sa:24'h00091A, e_ds:2'b11, e_sd:16'h0000, e_cq:8'hBE};
    vt[1] = '{we:1'b0, a:16'h0040, d:8'h00, q:16'h1234, e_sa:24'h000020, e_ds:2'b11, e_sd:16'h0000, e_cq:8'h34};
    vt[2] = '{we:1'b1, a:16'h0010, d:8'h5A, q:16'h0000, e_sa:24'h000008, e_ds:2'b01, e_sd:16'h5A5A, e_cq:8'h34};
    vt[3] = '{we:1'b1, a:16'h0011, d:8'hC3, q:16'h0000, e_sa:24'h000008, e_ds:2'b10, e_sd:16'hC3C3, e_cq:8'h34};
    vt[4] = '{we:1'b0, a:16'hFFFF, d:8'h00, q:16'hA55A, e_sa:24'h007FFF, e_ds:2'b11, e_sd:16'h0000, e_cq:8'hA5};

    // Reset with the controller ack phase at 1
    sd_ack = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("rst_flags", {27'd0, sd_req, sd_we, sd_ds, ldr_full, ldr_ovf}, 32'd0);
    chk("rst_sd_a", sd_a, 32'd0);
    chk("rst_sd_d", sd_d, 32'd0);
    chk("rst_cpu_q", cpu_q, 32'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);
    chk("sync_req", sd_req, 32'd1);
    repeat (4) @(negedge clk_sys);
    chk("no_spurious", sd_req, 32'd1);

    // CPU access table
    for (int i = 0; i < 5; i++) begin
      cpu_a  = vt[i].a;
      cpu_d  = vt[i].d;
      cpu_we = vt[i].we;
      cpu_oe = ~vt[i].we;
      cpu_cs = 1'b1;
      wait_issue($sformatf("v%0d_issue", i), n);
      chk($sformatf("v%0d_latency", i), n, 32'd2);
      chk($sformatf("v%0d_sd_a", i), sd_a, vt[i].e_sa);
      chk($sformatf("v%0d_sd_ds", i), sd_ds, vt[i].e_ds);
      chk($sformatf("v%0d_sd_we", i), sd_we, vt[i].we);
      if (vt[i].we) chk($sformatf("v%0d_sd_d", i), sd_d, vt[i].e_sd);
      do_ack(vt[i].q);
      cpu_cs = 1'b0; cpu_oe = 1'b0; cpu_we = 1'b0;
      @(negedge clk_sys);
      chk($sformatf("v%0d_cpu_q", i), cpu_q, vt[i].e_cq);
      chk($sformatf("v%0d_idle", i), 32'(sd_req == sd_ack), 32'd1);
    end

    // Held write level gives exactly one request
    begin
      int   tog = 0;
      logic prev = sd_req;
      cpu_a = 16'h0010; cpu_d = 8'h5A; cpu_we = 1'b1; cpu_cs = 1'b1;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk_sys);
        if (sd_req != prev) begin
          tog++;
          prev = sd_req;
          chk("hold_wr_fields", {sd_we, sd_ds, sd_d}, {13'd0, 1'b1, 2'b01, 16'h5A5A});
        end
        if (sd_req != sd_ack) sd_ack = sd_req;
      end
      chk("hold_wr_toggles", tog, 32'd1);
      cpu_cs = 1'b0; cpu_we = 1'b0;
      @(negedge clk_sys);
    end

    // FIFO fill with no ack, overflow on the fifth push
    for (int i = 0; i < 5; i++) begin
      push(25'h100 + 25'(i), 8'h10 + 8'(i));
      if (i == 2) chk("fifo_not_full3", ldr_full, 32'd0);
      if (i == 3) chk("fifo_full4", ldr_full, 32'd1);
    end
    chk("fifo_ovf", ldr_ovf, 32'd1);
    begin
      int nw = 0;
      logic [24:0] ea;
      logic [7:0]  ed;
      for (int c = 0; c < 60; c++) begin
        if (sd_req != sd_ack) begin
          if (nw < 4) begin
            ea = 25'h100 + 25'(nw);
            ed = 8'h10 + 8'(nw);
            chk($sformatf("ldr%0d_sd_a", nw), sd_a, ea[24:1]);
            chk($sformatf("ldr%0d_ds_we_d", nw), {sd_ds, sd_we, sd_d},
                {13'd0, (ea[0] ? 2'b10 : 2'b01), 1'b1, ed, ed});
          end
          nw++;
          sd_ack = sd_req;
        end
        @(negedge clk_sys);
      end
      chk("ldr_write_count", nw, 32'd4);
      chk("fifo_drained", ldr_full, 32'd0);
      chk("ovf_sticky", ldr_ovf, 32'd1);
    end

    // Three loader entries against a CPU changing address every cycle
    begin
      int exp_we[7] = '{1, 0, 1, 0, 1, 0, 0};
      int k = 0;
      for (int i = 0; i < 3; i++) push(25'h200 + 25'(i), 8'h20 + 8'(i));
      cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_we = 1'b0;
      for (int c = 0; c < 80 && k < 7; c++) begin
        if (sd_req != sd_ack) begin
          chk($sformatf("alt%0d_we", k), sd_we, exp_we[k]);
          k++;
          sd_q   = 16'h0F0F;
          sd_ack = sd_req;
        end
        cpu_a = cpu_a + 16'd1;
        @(negedge clk_sys);
      end
      chk("alt_count", k, 32'd7);
      cpu_cs = 1'b0; cpu_oe = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (sd_req != sd_ack) sd_ack = sd_req;
        @(negedge clk_sys);
      end
      chk("alt_idle", 32'(sd_req == sd_ack), 32'd1);
    end

    // Reset while a loader write is outstanding
    begin
      logic pend_req;
      int   t = 0;
      push(25'h300, 8'h33);
      push(25'h301, 8'h34);
      wait_issue("r6_issue", n);
      chk("r6_ldr_wait", sd_we, 32'd1);
      pend_req = sd_req;
      reset_n = 1'b0;
      #1;
      chk("r6_rst_flags", {27'd0, sd_req, sd_we, sd_ds, ldr_full, ldr_ovf}, 32'd0);
      chk("r6_rst_bus", {sd_a, sd_d}, 32'd0);
      sd_ack = pend_req;
      repeat (2) @(negedge clk_sys);
      reset_n = 1'b1;
      @(negedge clk_sys);
      for (int c = 0; c < 8; c++) begin
        if (sd_req != sd_ack) t++;
        @(negedge clk_sys);
      end
      chk("r6_no_dup", t, 32'd0);
      push(25'h400, 8'h44);
      wait_issue("r6_new_issue", n);
      chk("r6_new_sd_a", sd_a, 32'h000200);
      chk("r6_new_fields", {sd_ds, sd_we, sd_d}, {13'd0, 2'b01, 1'b1, 16'h4444});
      do_ack(16'h0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
